// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register pending-write scoreboard with RAW/WAW issue gating and writeback forwarding
module id_scoreboard #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_SRC        = 3,
    parameter int NUM_WB         = 2,
    parameter int CNT_WIDTH      = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush_i,
    input  logic                                issue_valid_i,
    output logic                                issue_ready_o,
    input  logic                                issue_rd_we_i,
    input  logic [REG_ADDR_WIDTH-1:0]           issue_rd_i,
    input  logic [NUM_SRC-1:0]                  issue_src_used_i,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]   issue_src_addr_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]       rf_data_i,
    output logic [NUM_SRC*DATA_WIDTH-1:0]       src_data_o,
    input  logic [NUM_WB-1:0]                   wb_valid_i,
    input  logic [NUM_WB*REG_ADDR_WIDTH-1:0]    wb_addr_i,
    input  logic [NUM_WB*DATA_WIDTH-1:0]        wb_data_i,
    output logic [REG_ADDR_WIDTH+CNT_WIDTH-1:0] outstanding_o,
    output logic                                err_o
);
    localparam int RAW  = REG_ADDR_WIDTH;
    localparam int DW   = DATA_WIDTH;
    localparam int NREG = 2 ** RAW;
    localparam int OW   = RAW + CNT_WIDTH;
    localparam int HB   = $clog2(NUM_WB + 1);
    localparam int CW   = (CNT_WIDTH > HB) ? CNT_WIDTH : HB;
    localparam logic [CNT_WIDTH-1:0] CMAX = '1;

    logic [CNT_WIDTH-1:0] r_cnt [NREG];
    logic [OW-1:0]        r_outstanding;
    logic                 r_err;
    logic [CW-1:0]        w_hits [NREG];
    logic [CNT_WIDTH-1:0] w_next [NREG];
    logic [OW-1:0]        w_total;
    logic                 w_err_set;
    logic                 w_hazard;
    logic                 w_acc;

    assign w_acc         = issue_valid_i & issue_ready_o;
    assign outstanding_o = r_outstanding;
    assign err_o         = r_err;

    // Count how many writeback ports retire each register this cycle (r0 never counted)
    always_comb begin
        for (int r = 0; r < NREG; r++) w_hits[r] = '0;
        for (int r = 1; r < NREG; r++)
            for (int j = 0; j < NUM_WB; j++)
                w_hits[r] = w_hits[r] + CW'(wb_valid_i[j] && wb_addr_i[j*RAW+:RAW] == RAW'(r));
    end

    // Issue gate: RAW hazard on any used source not cleared by same-cycle retirement, or WAW saturation
    always_comb begin
        w_hazard = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            logic [RAW-1:0] w_a;
            w_a = issue_src_addr_i[k*RAW+:RAW];
            if (issue_src_used_i[k] && w_a != '0 && CW'(r_cnt[w_a]) > w_hits[w_a]) w_hazard = 1'b1;
        end
        issue_ready_o = ~rst & ~flush_i & ~w_hazard &
                        ~(issue_rd_we_i && issue_rd_i != '0 && r_cnt[issue_rd_i] == CMAX);
    end

    // Operand forwarding: highest-index matching writeback port wins, r0 always reads zero
    always_comb begin
        src_data_o = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            logic [RAW-1:0] w_a;
            w_a = issue_src_addr_i[k*RAW+:RAW];
            src_data_o[k*DW+:DW] = rf_data_i[k*DW+:DW];
            for (int j = 0; j < NUM_WB; j++)
                if (wb_valid_i[j] && wb_addr_i[j*RAW+:RAW] == w_a) src_data_o[k*DW+:DW] = wb_data_i[j*DW+:DW];
            if (w_a == '0) src_data_o[k*DW+:DW] = '0;
        end
    end

    // Next counter values: add accepted issue, subtract retirements, clamp at zero and flag over-retirement
    always_comb begin
        w_err_set = 1'b0;
        w_total   = '0;
        for (int r = 0; r < NREG; r++) begin
            logic [CW:0] w_sum;
            w_sum = (CW+1)'(r_cnt[r]) + (CW+1)'(w_acc && issue_rd_we_i && issue_rd_i == RAW'(r) && r != 0);
            if (CW'(r_cnt[r]) < w_hits[r]) w_err_set = 1'b1;
            w_next[r] = (w_sum < (CW+1)'(w_hits[r])) ? '0 : CNT_WIDTH'(w_sum - (CW+1)'(w_hits[r]));
            w_total   = w_total + OW'(w_next[r]);
        end
    end

    // State update: reset clears everything, flush drops pending writes but keeps the sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else if (flush_i) begin
            for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
            r_outstanding <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) r_cnt[r] <= w_next[r];
            r_outstanding <= w_total;
            r_err         <= r_err | w_err_set;
        end
    end
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed scenarios plus randomized traffic checked against an integer scoreboard model
module tb_id_scoreboard;
    logic        clk = 1'b0;
    logic        rst, flush_i, issue_valid_i, issue_ready_o, issue_rd_we_i, err_o;
    logic [4:0]  issue_rd_i;
    logic [2:0]  issue_src_used_i;
    logic [14:0] issue_src_addr_i;
    logic [95:0] rf_data_i, src_data_o;
    logic [1:0]  wb_valid_i;
    logic [9:0]  wb_addr_i;
    logic [63:0] wb_data_i;
    logic [6:0]  outstanding_o;
    int          mcnt [32];
    bit          merr;
    int          n_tests = 0;
    int          n_fail = 0;

    id_scoreboard dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .issue_valid_i(issue_valid_i),
        .issue_ready_o(issue_ready_o), .issue_rd_we_i(issue_rd_we_i), .issue_rd_i(issue_rd_i),
        .issue_src_used_i(issue_src_used_i), .issue_src_addr_i(issue_src_addr_i),
        .rf_data_i(rf_data_i), .src_data_o(src_data_o), .wb_valid_i(wb_valid_i),
        .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic int hits(int a);
        int h = 0;
        for (int j = 0; j < 2; j++) if (wb_valid_i[j] && int'(wb_addr_i[j*5+:5]) == a) h++;
        return h;
    endfunction

    function automatic bit m_ready();
        if (rst || flush_i) return 1'b0;
        for (int k = 0; k < 3; k++) begin
            int a = int'(issue_src_addr_i[k*5+:5]);
            if (issue_src_used_i[k] && a != 0 && mcnt[a] > hits(a)) return 1'b0;
        end
        if (issue_rd_we_i && issue_rd_i != 0 && mcnt[issue_rd_i] == 3) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [95:0] m_src();
        logic [95:0] v = '0;
        for (int k = 0; k < 3; k++) begin
            int a = int'(issue_src_addr_i[k*5+:5]);
            v[k*32+:32] = rf_data_i[k*32+:32];
            for (int j = 0; j < 2; j++)
                if (wb_valid_i[j] && int'(wb_addr_i[j*5+:5]) == a) v[k*32+:32] = wb_data_i[j*32+:32];
            if (a == 0) v[k*32+:32] = 32'h0;
        end
        return v;
    endfunction

    function automatic int m_total();
        int s = 0;
        for (int r = 0; r < 32; r++) s += mcnt[r];
        return s;
    endfunction

    task automatic tick();
        int nx [32];
        bit ne = merr;
        bit acc = issue_valid_i && m_ready();
        for (int r = 0; r < 32; r++) begin
            int v;
            if (rst || flush_i || r == 0) begin
                nx[r] = 0;
            end else begin
                if (mcnt[r] < hits(r)) ne = 1'b1;
                v = mcnt[r] + ((acc && issue_rd_we_i && int'(issue_rd_i) == r) ? 1 : 0) - hits(r);
                nx[r] = (v < 0) ? 0 : v;
            end
        end
        if (rst) ne = 1'b0;
        else if (flush_i) ne = merr;
        @(posedge clk);
        #1;
        for (int r = 0; r < 32; r++) mcnt[r] = nx[r];
        merr = ne;
    endtask

    task automatic idle();
        flush_i = 0; issue_valid_i = 0; issue_rd_we_i = 0; issue_rd_i = 0;
        issue_src_used_i = 0; issue_src_addr_i = 0; rf_data_i = 0;
        wb_valid_i = 0; wb_addr_i = 0; wb_data_i = 0;
    endtask

    task automatic set_src(int k, bit u, int a, logic [31:0] d);
        issue_src_used_i[k] = u; issue_src_addr_i[k*5+:5] = 5'(a); rf_data_i[k*32+:32] = d;
    endtask

    task automatic set_wb(int j, bit v, int a, logic [31:0] d);
        wb_valid_i[j] = v; wb_addr_i[j*5+:5] = 5'(a); wb_data_i[j*32+:32] = d;
    endtask

    task automatic set_issue(bit v, bit we, int rd);
        issue_valid_i = v; issue_rd_we_i = we; issue_rd_i = 5'(rd);
    endtask

    task automatic test_reset();
        idle(); rst = 1; set_issue(1, 1, 4);
        #1;
        n_tests++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_mask_ready: got %b want 0", issue_ready_o); end
        tick(); tick();
        n_tests++; if (outstanding_o !== 7'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
        rst = 0; idle();
        set_src(0, 1, 12, 32'hA5A5_0001); set_src(1, 1, 30, 32'h1234_5678); set_src(2, 0, 1, 32'hCAFE_F00D);
        #1;
        n_tests++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", issue_ready_o); end
        n_tests++; if (src_data_o !== rf_data_i) begin n_fail++; $display("FAIL idle_rf_pass: got %h want %h", src_data_o, rf_data_i); end
        set_src(1, 1, 0, 32'hFFFF_FFFF);
        #1;
        n_tests++; if (src_data_o[63:32] !== 32'h0) begin n_fail++; $display("FAIL src_r0_zero: got %h want 0", src_data_o[63:32]); end
        tick();
    endtask

    task automatic test_issue_forward();
        idle(); set_issue(1, 1, 5);
        tick();
        n_tests++; if (outstanding_o !== 7'd1) begin n_fail++; $display("FAIL issue_r5_count: got %0d want 1", outstanding_o); end
        idle(); set_issue(1, 0, 0); set_src(0, 1, 5, 32'h0000_1111);
        #1;
        n_tests++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL raw_hazard_r5: got %b want 0", issue_ready_o); end
        set_wb(0, 1, 5, 32'hDEAD_BEEF);
        #1;
        n_tests++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL raw_cleared_by_wb: got %b want 1", issue_ready_o); end
        n_tests++; if (src_data_o[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fwd_wb0: got %h want deadbeef", src_data_o[31:0]); end
        tick();
        n_tests++; if (outstanding_o !== 7'd0) begin n_fail++; $display("FAIL r5_retired: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_dual_wb();
        idle(); set_issue(1, 1, 7);
        tick(); tick();
        n_tests++; if (outstanding_o !== 7'd2) begin n_fail++; $display("FAIL r7_two_pending: got %0d want 2", outstanding_o); end
        idle(); set_src(1, 1, 7, 32'h7777_7777);
        set_wb(0, 1, 7, 32'h11); set_wb(1, 1, 7, 32'h22);
        #1;
        n_tests++; if (src_data_o[63:32] !== 32'h22) begin n_fail++; $display("FAIL fwd_priority_wb1: got %h want 22", src_data_o[63:32]); end
        n_tests++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL dual_wb_ready: got %b want 1", issue_ready_o); end
        tick();
        n_tests++; if (outstanding_o !== 7'd0) begin n_fail++; $display("FAIL r7_drained: got %0d want 0", outstanding_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL dual_wb_no_err: got %b want 0", err_o); end
    endtask

    task automatic test_saturation();
        idle(); set_issue(1, 1, 3);
        tick(); tick(); tick();
        n_tests++; if (outstanding_o !== 7'd3) begin n_fail++; $display("FAIL r3_three_pending: got %0d want 3", outstanding_o); end
        #1;
        n_tests++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL waw_saturated: got %b want 0", issue_ready_o); end
        set_wb(0, 1, 3, 32'h3);
        #1;
        n_tests++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL waw_sat_with_wb: got %b want 0", issue_ready_o); end
        set_issue(0, 0, 0);
        tick();
        set_issue(1, 1, 3);
        #1;
        n_tests++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL waw_after_wb: got %b want 1", issue_ready_o); end
        tick();
        n_tests++; if (outstanding_o !== 7'd2) begin n_fail++; $display("FAIL issue_wb_net: got %0d want 2", outstanding_o); end
        idle(); set_issue(1, 1, 3);
        tick();
        set_wb(0, 1, 3, 32'h3); set_wb(1, 1, 3, 32'h3); set_issue(0, 0, 0);
        tick(); idle(); set_wb(0, 1, 3, 32'h3);
        tick();
        n_tests++; if (outstanding_o !== 7'd0) begin n_fail++; $display("FAIL r3_drained: got %0d want 0", outstanding_o); end
        idle();
    endtask

    task automatic test_flush();
        idle(); set_issue(1, 1, 10); tick();
        set_issue(1, 1, 11); tick();
        set_issue(1, 1, 12); tick();
        set_issue(1, 1, 13); tick();
        n_tests++; if (outstanding_o !== 7'd4) begin n_fail++; $display("FAIL four_pending: got %0d want 4", outstanding_o); end
        flush_i = 1; set_issue(1, 1, 14); set_wb(0, 1, 10, 32'h10);
        #1;
        n_tests++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_issue: got %b want 0", issue_ready_o); end
        tick();
        n_tests++; if (outstanding_o !== 7'd0) begin n_fail++; $display("FAIL flush_clears: got %0d want 0", outstanding_o); end
        idle(); set_issue(1, 0, 0); set_src(0, 1, 14, 32'h1); set_src(1, 1, 10, 32'h2);
        #1;
        n_tests++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL no_hazard_after_flush: got %b want 1", issue_ready_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL flush_no_err: got %b want 0", err_o); end
        tick();
    endtask

    task automatic test_error();
        idle(); set_wb(0, 1, 0, 32'h5); tick();
        n_tests++; if (err_o !== 1'b0 || outstanding_o !== 7'd0) begin n_fail++; $display("FAIL wb_r0_ignored: got err=%b out=%0d want 0/0", err_o, outstanding_o); end
        idle(); set_wb(1, 1, 9, 32'h9); tick();
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL wb_nonpending_err: got %b want 1", err_o); end
        n_tests++; if (outstanding_o !== 7'd0) begin n_fail++; $display("FAIL r9_no_underflow: got %0d want 0", outstanding_o); end
        idle(); set_issue(1, 1, 9); tick();
        n_tests++; if (outstanding_o !== 7'd1) begin n_fail++; $display("FAIL r9_issue_after_err: got %0d want 1", outstanding_o); end
        idle(); flush_i = 1; tick(); idle(); tick();
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_o); end
        rst = 1; tick(); rst = 0;
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_cleared_by_rst: got %b want 0", err_o); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            flush_i = ($urandom_range(0, 39) == 0);
            set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7));
            for (int k = 0; k < 3; k++) set_src(k, $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
            for (int j = 0; j < 2; j++) begin
                int a = $urandom_range(0, 7);
                bit v = (mcnt[a] > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
                set_wb(j, v, a, $urandom);
            end
            #1;
            n_tests++;
            if (issue_ready_o !== m_ready() || src_data_o !== m_src()) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rnd_comb c=%0d: ready=%b want %b data=%h want %h", c, issue_ready_o, m_ready(), src_data_o, m_src());
            end
            tick();
            n_tests++;
            if (outstanding_o !== 7'(m_total()) || err_o !== merr) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rnd_state c=%0d: out=%0d want %0d err=%b want %b", c, outstanding_o, m_total(), err_o, merr);
            end
        end
        idle(); rst = 0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        merr = 0;
        test_reset();
        test_issue_forward();
        test_dual_wb();
        test_saturation();
        test_flush();
        test_error();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
